capture_sequencer: RTL and testbench

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

---
 rtl/capture_sequencer_if.sv | 19 +
 rtl/capture_sequencer.sv | 175 +++++++++++++++++
 tb/tb_capture_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : capture_sequencer_if
//  Purpose  : Streaming word bus (valid / last / 32-bit data) with no
//             backpressure. Carries the ADC input stream into the sequencer
//             and the gated stream out to the writer.
//  Modports : master - drives tvalid, tlast, tdata
//             slave  - observes tvalid, tlast, tdata
//  Revision : 1.0 - initial release
// ============================================================================
interface capture_sequencer_if;
   logic        tvalid;
   logic        tlast;
   logic [31:0] tdata;

   modport master (output tvalid, output tlast, output tdata);
   modport slave  (input  tvalid, input  tlast, input  tdata);
endinterface
`default_nettype wire

// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : capture_sequencer
//  Purpose  : Sequences ADC burst captures. A start command clears the ADC
//             for two cycles, then opens a capture window that forwards the
//             ADC stream to the writer. Each tlast closes a burst; bursts are
//             separated by a programmable hold-off gap. Runs end on the
//             configured burst count, on an idle-word timeout, or on abort.
//  Ports    : aclk, areset          - clock, synchronous active-high reset
//             cfg_start, cfg_abort  - single-cycle command pulses
//             cfg_bursts            - bursts per run (0 = until abort)
//             cfg_holdoff           - gap cycles between bursts (min 1)
//             cfg_timeout           - idle-word timeout cycles (0 = off)
//             cfg_limiter           - burst length exponent, latched on start
//             adc_limiter, adc_nreset_trigger, adc_nreset_max_sum - ADC ctl
//             s_axis (slave)        - ADC stream in
//             m_axis (master)       - gated stream out, 1-cycle latency
//             busy, done, timed_out, bursts_done, words_done - status
//  Options  : CAPTURE_SEQ_MAXSUM_CLR_EN - when defined, adc_nreset_max_sum is
//             pulled low during the two CLEAR cycles of a run start;
//             otherwise it is held at 1.
//  Revision : 1.0 - initial release
// ============================================================================
module capture_sequencer #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 cfg_start,
   input  logic                 cfg_abort,
   input  logic [15:0]          cfg_bursts,
   input  logic [CNT_WIDTH-1:0] cfg_holdoff,
   input  logic [CNT_WIDTH-1:0] cfg_timeout,
   input  logic [7:0]           cfg_limiter,
   output logic [7:0]           adc_limiter,
   output logic                 adc_nreset_trigger,
   output logic                 adc_nreset_max_sum,
   capture_sequencer_if.slave   s_axis,
   capture_sequencer_if.master  m_axis,
   output logic                 busy,
   output logic                 done,
   output logic                 timed_out,
   output logic [15:0]          bursts_done,
   output logic [CNT_WIDTH-1:0] words_done
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_CAPTURE = 3'd2,
      S_HOLDOFF = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_clr_cnt;
   logic [CNT_WIDTH-1:0] r_hold_cnt;
   logic [CNT_WIDTH-1:0] r_to_cnt;

   logic                 w_accept;
   logic                 w_tlast_acc;
   logic [15:0]          w_bursts_inc;
   logic                 w_last_burst;
   logic [CNT_WIDTH-1:0] w_to_inc;
   logic                 w_timeout;
   logic [CNT_WIDTH-1:0] w_hold_inc;
   logic                 w_hold_end;
   logic                 w_start_ok;
   logic                 w_set_to;

   // Words are only ever taken while the capture window is open.
   assign w_accept    = (r_state == S_CAPTURE) && s_axis.tvalid;
   assign w_tlast_acc = w_accept && s_axis.tlast;

   // Saturate so an endless run (cfg_bursts = 0) never wraps back to 0.
   assign w_bursts_inc = (bursts_done == 16'hFFFF) ? bursts_done : bursts_done + 16'd1;
   assign w_last_burst = (cfg_bursts != 16'd0) && (w_bursts_inc == cfg_bursts);

   // An accepted word restarts the idle count, so it can never time out in
   // the same cycle; a tlast at expiry therefore closes the burst normally.
   assign w_to_inc  = r_to_cnt + 1'b1;
   assign w_timeout = (cfg_timeout != '0) && !w_accept && (w_to_inc == cfg_timeout);

   // ">=" makes a hold-off of 0 behave like 1.
   assign w_hold_inc = r_hold_cnt + 1'b1;
   assign w_hold_end = (w_hold_inc >= cfg_holdoff);

   // Abort has no effect in IDLE, so start is honoured there even alongside it.
   assign w_start_ok = cfg_start &&
                       ((r_state == S_IDLE) || ((r_state == S_DONE) && !cfg_abort));

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge aclk) begin
      if (areset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_set_to    = 1'b0;
      case (r_state)
         S_IDLE:    if (w_start_ok) w_state_nxt = S_CLEAR;
         S_CLEAR:   if (r_clr_cnt)  w_state_nxt = S_CAPTURE;
         S_CAPTURE: begin
            if (w_tlast_acc) begin
               w_state_nxt = w_last_burst ? S_DONE : S_HOLDOFF;
            end else if (w_timeout) begin
               w_state_nxt = S_DONE;
               w_set_to    = 1'b1;
            end
         end
         S_HOLDOFF: if (w_hold_end) w_state_nxt = S_CAPTURE;
         S_DONE:    if (w_start_ok) w_state_nxt = S_CLEAR;
         default:   w_state_nxt = S_IDLE;
      endcase
      if (cfg_abort && (r_state != S_IDLE)) begin
         w_state_nxt = S_DONE;
         w_set_to    = 1'b0;
      end
   end

   // ----------------------------------------------------------- datapath ---
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_clr_cnt     <= 1'b0;
         r_hold_cnt    <= '0;
         r_to_cnt      <= '0;
         m_axis.tvalid <= 1'b0;
         m_axis.tlast  <= 1'b0;
         m_axis.tdata  <= 32'd0;
         adc_limiter   <= 8'd0;
         bursts_done   <= 16'd0;
         words_done    <= '0;
         done          <= 1'b0;
         timed_out     <= 1'b0;
      end else begin
         r_clr_cnt  <= (r_state == S_CLEAR) && !r_clr_cnt;
         r_hold_cnt <= (r_state == S_HOLDOFF) ? w_hold_inc : '0;
         r_to_cnt   <= ((r_state == S_CAPTURE) && !w_accept) ? w_to_inc : '0;

         m_axis.tvalid <= w_accept;
         m_axis.tlast  <= w_tlast_acc;
         if (w_accept) m_axis.tdata <= s_axis.tdata;

         if (w_start_ok) begin
            adc_limiter <= cfg_limiter;
            bursts_done <= 16'd0;
            words_done  <= '0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
         end else begin
            if (w_accept)               words_done  <= words_done + 1'b1;
            if (w_tlast_acc)            bursts_done <= w_bursts_inc;
            if (w_state_nxt == S_DONE)  done        <= 1'b1;
            if (w_set_to)               timed_out   <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------ outputs ---
   assign busy               = (r_state == S_CLEAR) || (r_state == S_CAPTURE) ||
                               (r_state == S_HOLDOFF);
   assign adc_nreset_trigger = (r_state == S_CAPTURE);

`ifdef CAPTURE_SEQ_MAXSUM_CLR_EN
   // CLEAR is only reachable from a start command, so this covers the run
   // start and never the resume after a hold-off.
   assign adc_nreset_max_sum = (r_state != S_CLEAR);
`else
   assign adc_nreset_max_sum = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_capture_sequencer
//  Purpose  : Self-checking bench for capture_sequencer: a per-cycle vector
//             table plus directed multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_capture_sequencer;

   logic        aclk = 1'b0;
   logic        areset;
   logic        cfg_start, cfg_abort;
   logic [15:0] cfg_bursts;
   logic [31:0] cfg_holdoff, cfg_timeout;
   logic [7:0]  cfg_limiter;
   logic [7:0]  adc_limiter;
   logic        adc_nreset_trigger, adc_nreset_max_sum;
   logic        busy, done, timed_out;
   logic [15:0] bursts_done;
   logic [31:0] words_done;

   capture_sequencer_if s_if ();
   capture_sequencer_if m_if ();

   capture_sequencer #(.CNT_WIDTH(32)) dut (
      .aclk               (aclk),
      .areset             (areset),
      .cfg_start          (cfg_start),
      .cfg_abort          (cfg_abort),
      .cfg_bursts         (cfg_bursts),
      .cfg_holdoff        (cfg_holdoff),
      .cfg_timeout        (cfg_timeout),
      .cfg_limiter        (cfg_limiter),
      .adc_limiter        (adc_limiter),
      .adc_nreset_trigger (adc_nreset_trigger),
      .adc_nreset_max_sum (adc_nreset_max_sum),
      .s_axis             (s_if.slave),
      .m_axis             (m_if.master),
      .busy               (busy),
      .done               (done),
      .timed_out          (timed_out),
      .bursts_done        (bursts_done),
      .words_done         (words_done)
   );

   always #5 aclk = ~aclk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic a, input logic v, input logic l,
                        input logic [31:0] d);
      cfg_start   = s;
      cfg_abort   = a;
      s_if.tvalid = v;
      s_if.tlast  = l;
      s_if.tdata  = d;
   endtask

   // Bounded wait for the capture window to open (called at a negedge).
   task automatic wait_trig();
      int k = 0;
      while (!adc_nreset_trigger && k < 20) begin
         @(negedge aclk);
         k++;
      end
      chk("wait_trig", {31'd0, adc_nreset_trigger}, 32'd1);
   endtask

   typedef struct packed {
      logic        start, abort, tvalid, tlast;
      logic [31:0] tdata;
      logic        e_busy, e_trig, e_mtv, e_mtlast;
      logic [31:0] e_mdata;
      logic [31:0] e_words;
      logic [15:0] e_bursts;
      logic        e_done;
   } vec_t;

   function automatic vec_t mk(input logic s, a, v, l, input logic [31:0] d,
                               input logic eb, et, emv, eml, input logic [31:0] emd,
                               input logic [31:0] ew, input logic [15:0] ebu,
                               input logic ed);
      vec_t r;
      r.start = s; r.abort = a; r.tvalid = v; r.tlast = l; r.tdata = d;
      r.e_busy = eb; r.e_trig = et; r.e_mtv = emv; r.e_mtlast = eml;
      r.e_mdata = emd; r.e_words = ew; r.e_bursts = ebu; r.e_done = ed;
      return r;
   endfunction

   vec_t vecs [10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ms, n_fwd, n_gap, n_cap, idx;
      bit seen_cap, finished;

      //                s  a  v  l  data        busy trig mtv mtl mdata       words b  done
      vecs[0] = mk(1'b0,1'b0,1'b1,1'b0,32'hAA, 1'b0,1'b0,1'b0,1'b0,32'h0,  32'd0,16'd0,1'b0);
      vecs[1] = mk(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,1'b0,1'b0,32'h0,  32'd0,16'd0,1'b0);
      vecs[2] = mk(1'b0,1'b0,1'b1,1'b0,32'hBB, 1'b1,1'b0,1'b0,1'b0,32'h0,  32'd0,16'd0,1'b0);
      vecs[3] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,  1'b1,1'b1,1'b0,1'b0,32'h0,  32'd0,16'd0,1'b0);
      vecs[4] = mk(1'b0,1'b0,1'b1,1'b0,32'h11, 1'b1,1'b1,1'b1,1'b0,32'h11, 32'd1,16'd0,1'b0);
      vecs[5] = mk(1'b0,1'b0,1'b1,1'b1,32'h22, 1'b0,1'b0,1'b1,1'b1,32'h22, 32'd2,16'd1,1'b1);
      vecs[6] = mk(1'b0,1'b0,1'b1,1'b0,32'h33, 1'b0,1'b0,1'b0,1'b0,32'h0,  32'd2,16'd1,1'b1);
      vecs[7] = mk(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,1'b0,1'b0,32'h0,  32'd0,16'd0,1'b0);
      vecs[8] = mk(1'b0,1'b1,1'b0,1'b0,32'h0,  1'b0,1'b0,1'b0,1'b0,32'h0,  32'd0,16'd0,1'b1);
      vecs[9] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,1'b0,1'b0,1'b0,32'h0,  32'd0,16'd0,1'b1);

      // ---- reset state
      areset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      cfg_bursts = 16'd1; cfg_holdoff = 32'd2; cfg_timeout = 32'd0; cfg_limiter = 8'd5;
      repeat (3) @(negedge aclk);
      chk("rst_busy",    {31'd0, busy}, 32'd0);
      chk("rst_done",    {31'd0, done}, 32'd0);
      chk("rst_to",      {31'd0, timed_out}, 32'd0);
      chk("rst_words",   words_done, 32'd0);
      chk("rst_bursts",  {16'd0, bursts_done}, 32'd0);
      chk("rst_mtv",     {31'd0, m_if.tvalid}, 32'd0);
      chk("rst_lim",     {24'd0, adc_limiter}, 32'd0);
      chk("rst_trig",    {31'd0, adc_nreset_trigger}, 32'd0);
      chk("rst_maxsum",  {31'd0, adc_nreset_max_sum}, 32'd1);
      areset = 1'b0;

      // ---- per-cycle vector table
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].start, vecs[i].abort, vecs[i].tvalid, vecs[i].tlast, vecs[i].tdata);
         @(negedge aclk);
         chk($sformatf("v%0d_busy", i),   {31'd0, busy}, {31'd0, vecs[i].e_busy});
         chk($sformatf("v%0d_trig", i),   {31'd0, adc_nreset_trigger}, {31'd0, vecs[i].e_trig});
         chk($sformatf("v%0d_mtv", i),    {31'd0, m_if.tvalid}, {31'd0, vecs[i].e_mtv});
         chk($sformatf("v%0d_mtlast", i), {31'd0, m_if.tlast}, {31'd0, vecs[i].e_mtlast});
         if (vecs[i].e_mtv)
            chk($sformatf("v%0d_mdata", i), m_if.tdata, vecs[i].e_mdata);
         chk($sformatf("v%0d_words", i),  words_done, vecs[i].e_words);
         chk($sformatf("v%0d_bursts", i), {16'd0, bursts_done}, {16'd0, vecs[i].e_bursts});
         chk($sformatf("v%0d_done", i),   {31'd0, done}, {31'd0, vecs[i].e_done});
      end
      chk("tbl_limiter", {24'd0, adc_limiter}, 32'd5);

      // ---- two bursts of 4 words, hold-off 5, stream also driven in gaps
      cfg_bursts = 16'd2; cfg_holdoff = 32'd5; cfg_timeout = 32'd0; cfg_limiter = 8'd9;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge aclk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      n_ms = 0; n_fwd = 0; n_gap = 0; idx = 0; seen_cap = 0; finished = 0;
      for (int c = 0; c < 80 && !finished; c++) begin
         if (!adc_nreset_max_sum) n_ms++;
         if (m_if.tvalid) begin
            chk("ab_data", m_if.tdata, n_fwd);
            chk("ab_tlast", {31'd0, m_if.tlast}, {31'd0, (n_fwd % 4) == 3});
            n_fwd++;
         end
         if (busy && !adc_nreset_trigger && seen_cap) n_gap++;
         if (adc_nreset_trigger) seen_cap = 1;
         if (done) finished = 1;
         else begin
            if (adc_nreset_trigger) begin
               drive(1'b0, 1'b0, 1'b1, (idx % 4) == 3, idx);
               idx++;
            end else begin
               drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD0000);
            end
            @(negedge aclk);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("ab_finished", {31'd0, finished}, 32'd1);
      chk("ab_fwd",      n_fwd, 32'd8);
      chk("ab_gap",      n_gap, 32'd5);
      chk("ab_bursts",   {16'd0, bursts_done}, 32'd2);
      chk("ab_words",    words_done, 32'd8);
      chk("ab_to",       {31'd0, timed_out}, 32'd0);
      chk("ab_limiter",  {24'd0, adc_limiter}, 32'd9);
`ifdef CAPTURE_SEQ_MAXSUM_CLR_EN
      chk("ab_maxsum_low", n_ms, 32'd2);
`else
      chk("ab_maxsum_low", n_ms, 32'd0);
`endif
      @(negedge aclk);
      chk("ab_done_sticky", {31'd0, done}, 32'd1);
      chk("ab_idle_drop",   {31'd0, m_if.tvalid}, 32'd0);

      // ---- idle-word timeout of 10
      cfg_bursts = 16'd0; cfg_holdoff = 32'd1; cfg_timeout = 32'd10;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge aclk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      n_cap = 0; finished = 0;
      for (int c = 0; c < 40 && !finished; c++) begin
         if (adc_nreset_trigger) n_cap++;
         if (done) finished = 1;
         else @(negedge aclk);
      end
      chk("to_finished", {31'd0, finished}, 32'd1);
      chk("to_cap_cycles", n_cap, 32'd10);
      chk("to_flag",     {31'd0, timed_out}, 32'd1);
      chk("to_words",    words_done, 32'd0);

      // ---- tlast in the same cycle the timeout expires
      cfg_timeout = 32'd3;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge aclk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("tt_to_cleared", {31'd0, timed_out}, 32'd0);
      wait_trig();
      repeat (2) @(negedge aclk);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h77);
      @(negedge aclk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("tt_busy",   {31'd0, busy}, 32'd1);
      chk("tt_trig",   {31'd0, adc_nreset_trigger}, 32'd0);
      chk("tt_to",     {31'd0, timed_out}, 32'd0);
      chk("tt_bursts", {16'd0, bursts_done}, 32'd1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      @(negedge aclk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("tt_abort_done", {31'd0, done}, 32'd1);

      // ---- abort with simultaneous start on the third word
      cfg_timeout = 32'd0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge aclk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      wait_trig();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd100);
      @(negedge aclk);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd101);
      @(negedge aclk);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd102);
      @(negedge aclk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("ab3_done",  {31'd0, done}, 32'd1);
      chk("ab3_busy",  {31'd0, busy}, 32'd0);
      chk("ab3_words", words_done, 32'd3);
      chk("ab3_mtv",   {31'd0, m_if.tvalid}, 32'd1);
      chk("ab3_mdata", m_if.tdata, 32'd102);
      @(negedge aclk);
      chk("ab3_start_ignored", {31'd0, done}, 32'd1);
      chk("ab3_words_kept",    words_done, 32'd3);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge aclk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("rs_words", words_done, 32'd0);
      chk("rs_done",  {31'd0, done}, 32'd0);
      chk("rs_busy",  {31'd0, busy}, 32'd1);

      // ---- reset in the middle of a capture
      wait_trig();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h55);
      @(negedge aclk);
      chk("mr_words_pre", words_done, 32'd1);
      areset = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h56);
      @(negedge aclk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("mr_mtv",    {31'd0, m_if.tvalid}, 32'd0);
      chk("mr_busy",   {31'd0, busy}, 32'd0);
      chk("mr_trig",   {31'd0, adc_nreset_trigger}, 32'd0);
      chk("mr_words",  words_done, 32'd0);
      chk("mr_bursts", {16'd0, bursts_done}, 32'd0);
      chk("mr_done",   {31'd0, done}, 32'd0);
      chk("mr_lim",    {24'd0, adc_limiter}, 32'd0);
      chk("mr_maxsum", {31'd0, adc_nreset_max_sum}, 32'd1);
      areset = 1'b0;
      @(negedge aclk);
      chk("mr_idle", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
